// File: rtl/img_pkg.sv
// img_pkg: frame geometry and streaming FSM states shared by image-side blocks
package img_pkg;
  localparam int IMG_W = 256;
  localparam int IMG_H = 256;
  localparam int N_PIXELS_DEF = IMG_W * IMG_H;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DONE} stream_state_t;
endpackage

// File: rtl/image_addr_counter.sv
// image_addr_counter: sequential pixel address generator with terminal-count flag
//   clk, rst (async, active-low)
//   load : restart at BASE_ADDR, pixel index 0
//   inc  : advance address and pixel index by one (address wraps modulo 2^ADDR_W)
//   addr : current registered address
//   last : current pixel index is N_PIXELS-1
module image_addr_counter
  import img_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int N_PIXELS = N_PIXELS_DEF,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  logic [ADDR_W-1:0] pixIdx;
  // index is tracked separately so the flag is independent of BASE_ADDR wrap-around
  assign last = pixIdx == ADDR_W'(N_PIXELS - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      addr   <= BASE_ADDR;
      pixIdx <= '0;
    end else if (load) begin
      addr   <= BASE_ADDR;
      pixIdx <= '0;
    end else if (inc) begin
      addr   <= addr + ADDR_W'(1);
      pixIdx <= pixIdx + ADDR_W'(1);
    end
endmodule

// File: rtl/image_stream_out.sv
// image_stream_out: drains one frame from the processed-image memory onto a valid/ready byte stream
//   clk, rst (async, active-low)
//   start/abort           : frame request / cancel
//   mem_addr, mem_rd      : memory read port (data valid the cycle after the address)
//   tx_data/tx_valid/tx_ready : byte stream to the sink
//   busy, done, byte_cnt  : status
module image_stream_out
  import img_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 8,
  parameter int N_PIXELS = N_PIXELS_DEF,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] byte_cnt
);
  stream_state_t state;
  logic last;
  logic load;
  logic inc;
  logic stop;
  assign stop = state != IDLE && abort;
  assign load = state == IDLE && start;
  // tx_ready only steers the address register, never an output combinationally
  assign inc = state == HOLD && !abort && tx_ready && !last;
  image_addr_counter #(
    .ADDR_W(ADDR_W),
    .N_PIXELS(N_PIXELS),
    .BASE_ADDR(BASE_ADDR)
  ) addrCounter (
    .clk(clk),
    .rst(rst),
    .load(load),
    .inc(inc),
    .addr(mem_addr),
    .last(last)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state    <= IDLE;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      byte_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state    <= IDLE;
        tx_valid <= 1'b0;
        busy     <= 1'b0;
      end else
        case (state)
          IDLE:
            if (start) begin
              state    <= REQ;
              busy     <= 1'b1;
              byte_cnt <= '0;
            end
          REQ: state <= WAIT;
          WAIT: begin
            tx_data  <= mem_rd;
            tx_valid <= 1'b1;
            state    <= HOLD;
          end
          HOLD:
            if (tx_ready) begin
              tx_valid <= 1'b0;
              byte_cnt <= byte_cnt + ADDR_W'(1);
              state    <= last ? DONE : REQ;
              // done is registered on entry so it is high exactly for the DONE cycle
              done     <= last;
            end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
    end
endmodule
